csa_accum_ctrl: RTL and testbench

Multi-operand accumulator controller for the wide modular-arithmetic datapath. It accepts a stream of WIDTH-bit operands over a valid/ready handshake and folds each one, one beat per cycle, into a redundant carry-save pair (S, C) using a single WIDTH-bit 3:2 compressor row. On the last operand it resolves S+C to binary with a chunked ripple adder, CHUNK bits per cycle, then presents the sum modulo 2^WIDTH on an output valid/ready handshake. It sits between operand/partial-product producers and the quotient/remainder stages.

---
 rtl/csa_accum_ctrl_pkg.sv | 19 +
 rtl/csa_accum_ctrl_row.sv | 15 +
 rtl/csa_accum_ctrl.sv | 126 ++++++++++++
 tb/tb_csa_accum_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_accum_ctrl_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator controller.
package csa_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic int nch(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // Counter/index width for n distinct values, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_accum_ctrl_row.sv
// WIDTH-bit bitwise 3:2 compressor row: three operands in, sum and carry vectors out.
module csa_row #(
  parameter int WIDTH = 3152
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: folds operands into a carry-save pair, then resolves
// the pair to binary CHUNK bits per cycle and offers the sum mod 2^WIDTH.
module csa_accum_ctrl
  import csa_pkg::*;
#(
  parameter int WIDTH = 3152,
  parameter int CHUNK = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int NCH   = nch(WIDTH, CHUNK);
  localparam int IDX_W = idx_w(NCH);
  localparam int PW    = NCH * CHUNK;
  localparam int BW    = idx_w(PW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  state_t           state;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] c_q;
  logic [IDX_W-1:0] idx_q;
  logic             cy_q;

  logic [WIDTH-1:0] row_s;
  logic [WIDTH-1:0] row_c;

  logic [PW-1:0]    s_pad;
  logic [PW-1:0]    c_pad;
  logic [PW-1:0]    s_res_pad;
  logic [BW-1:0]    base;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] s_res;

  csa_row #(
    .WIDTH (WIDTH)
  ) u_row (
    .x (s_q),
    .y (c_q),
    .z (in_data),
    .s (row_s),
    .c (row_c)
  );

  // Zero padding to a whole number of chunks masks the short final chunk;
  // anything written above WIDTH is dropped when the result is narrowed.
  always_comb begin
    s_pad                = '0;
    c_pad                = '0;
    s_pad[WIDTH-1:0]     = s_q;
    c_pad[WIDTH-1:0]     = c_q;
    base                 = BW'(idx_q) * BW'(CHUNK);
    csum                 = {1'b0, s_pad[base +: CHUNK]}
                         + {1'b0, c_pad[base +: CHUNK]}
                         + {{CHUNK{1'b0}}, cy_q};
    s_res_pad            = s_pad;
    s_res_pad[base +: CHUNK] = csum[CHUNK-1:0];
    s_res                = s_res_pad[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCUM;
      s_q       <= '0;
      c_q       <= '0;
      idx_q     <= '0;
      cy_q      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid && in_ready) begin
            s_q <= row_s;
            // Carry vector weighs one bit higher; its MSB falls off (mod 2^WIDTH).
            c_q <= row_c << 1;
            if (in_last) begin
              state    <= RESOLVE;
              idx_q    <= '0;
              cy_q     <= 1'b0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        RESOLVE: begin
          s_q   <= s_res;
          cy_q  <= csum[CHUNK];
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            s_q       <= '0;
            c_q       <= '0;
            state     <= ACCUM;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = s_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Scoreboard bench for csa_accum_ctrl: a 16/4 instance for most sequences and an
// 18/4 instance for the short-tail case.
module tb_csa_accum_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_busy;
  logic [15:0] a_in_data, a_out_data;

  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_busy;
  logic [17:0] b_in_data, b_out_data;

  typedef struct {
    logic [31:0] data;
    int          beats;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int tests = 0;
  int fails = 0;
  int a_beats = 0;
  int b_beats = 0;
  int ready_mode = 1;

  csa_accum_ctrl #(.WIDTH(16), .CHUNK(4)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .in_last   (a_in_last),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .busy      (a_busy)
  );

  csa_accum_ctrl #(.WIDTH(18), .CHUNK(4)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_last   (b_in_last),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .busy      (b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] d, input int n);
    exp_t e;
    e.data  = d;
    e.beats = n;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] d, input int n);
    exp_t e;
    e.data  = d;
    e.beats = n;
    qb.push_back(e);
  endtask

  // Monitors: sample between edges, pop on an output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        a_beats = 0;
      end else begin
        if (a_in_valid && a_in_ready) a_beats++;
        if (a_out_valid && a_out_ready) begin
          if (qa.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL a_unexpected_out: actual 0x%0h, required no output", a_out_data);
          end else begin
            ea = qa.pop_front();
            check("a_data", 32'(a_out_data), ea.data);
            check("a_beats", a_beats, ea.beats);
          end
          a_beats = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        b_beats = 0;
      end else begin
        if (b_in_valid && b_in_ready) b_beats++;
        if (b_out_valid && b_out_ready) begin
          if (qb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL b_unexpected_out: actual 0x%0h, required no output", b_out_data);
          end else begin
            eb = qb.pop_front();
            check("b_data", 32'(b_out_data), eb.data);
            check("b_beats", b_beats, eb.beats);
          end
          b_beats = 0;
        end
      end
    end
  end

  initial begin
    a_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       a_out_ready = 1'b0;
        1:       a_out_ready = 1'b1;
        default: a_out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send_a(input logic [15:0] d, input logic last);
    int n;
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_last  = last;
    n = 0;
    while (a_in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL a_in_ready_timeout: actual 0, required 1");
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic send_b(input logic [17:0] d, input logic last);
    int n;
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_last  = last;
    n = 0;
    while (b_in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL b_in_ready_timeout: actual 0, required 1");
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  // Called in the cycle after the last accept; counts cycles from the accept
  // cycle to the first cycle with out_valid high.
  task automatic wait_a(output int lat, output int busy_bad);
    lat = 1;
    busy_bad = 0;
    while (a_out_valid !== 1'b1 && lat < 100) begin
      if (a_busy !== 1'b1) busy_bad++;
      @(posedge clk); #1;
      lat++;
    end
    if (a_busy !== 1'b1) busy_bad++;
  endtask

  task automatic wait_b(output int lat);
    lat = 1;
    while (b_out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while (qa.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int lat, bb, bad;
    logic [15:0] hold, d, sum;
    int nb, gap;

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0;
    b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(a_in_ready), 32'd1);
    check("reset_out_valid", 32'(a_out_valid), 32'd0);
    check("reset_out_data", 32'(a_out_data), 32'd0);
    check("reset_busy", 32'(a_busy), 32'd0);
    rst_n = 1'b1;

    // Three-beat sum, latency and busy coverage.
    push_a(32'h0006, 3);
    send_a(16'h0001, 1'b0);
    send_a(16'h0002, 1'b0);
    send_a(16'h0003, 1'b1);
    wait_a(lat, bb);
    check("a_latency", lat, 5);
    check("a_busy_resolve_done", bb, 0);

    // Carry through three chunks, then wrap to zero.
    push_a(32'h1000, 2);
    send_a(16'h0FFF, 1'b0);
    send_a(16'h0001, 1'b1);
    push_a(32'h0000, 2);
    send_a(16'hFFFE, 1'b0);
    send_a(16'h0002, 1'b1);

    // Short final chunk on the 18-bit instance.
    push_b(32'h00000, 2);
    send_b(18'h3FFFF, 1'b0);
    send_b(18'h00001, 1'b1);
    wait_b(lat);
    check("b_latency", lat, 6);

    drain_a();

    // Backpressure in DONE with a competing input beat.
    ready_mode = 0;
    push_a(32'h0030, 2);
    send_a(16'h0010, 1'b0);
    send_a(16'h0020, 1'b1);
    wait_a(lat, bb);
    hold = a_out_data;
    a_in_valid = 1'b1;
    a_in_data  = 16'h1234;
    a_in_last  = 1'b0;
    bad = 0;
    repeat (10) begin
      if (a_out_valid !== 1'b1 || a_out_data !== hold || a_in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("a_backpressure_hold", bad, 0);
    a_in_valid = 1'b0;
    ready_mode = 1;
    push_a(32'h0007, 1);
    send_a(16'h0007, 1'b1);
    drain_a();

    // Abort in the middle of resolution.
    send_a(16'h0009, 1'b0);
    send_a(16'h0003, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_out_valid", 32'(a_out_valid), 32'd0);
    check("abort_in_ready", 32'(a_in_ready), 32'd1);
    check("abort_busy", 32'(a_busy), 32'd0);
    push_a(32'h0005, 1);
    send_a(16'h0005, 1'b1);
    drain_a();

    // Random lengths, data, input gaps and output stalls.
    ready_mode = 2;
    for (int s = 0; s < 6; s++) begin
      nb  = $urandom_range(1, 40);
      sum = '0;
      for (int i = 0; i < nb; i++) begin
        d = 16'($urandom);
        sum = sum + d;
        if (i == nb - 1) push_a(32'(sum), nb);
        send_a(d, (i == nb - 1) ? 1'b1 : 1'b0);
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
    end
    drain_a();
    ready_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
